// File: rtl/traffic_light_ctrl.sv
// Two-road (NS/EW) intersection controller with all-red clearance, latched
// pedestrian walk phase, clock-enable freeze and flashing-yellow fault mode.
//
// Ports:
//   clock       rising-edge system clock
//   reset       asynchronous, active-high reset
//   enable      1 = advance phase timer, 0 = freeze state/counter/blink
//   ped_req     pedestrian request (level or single-cycle pulse)
//   flash_mode  1 = enter/stay in flashing-yellow mode
//   light_ns    NS lights {red,yellow,green}
//   light_ew    EW lights {red,yellow,green}
//   walk        pedestrian walk lamp
//   state_o     current state code
module traffic_light_ctrl #(
  parameter int unsigned GREEN_CYCLES  = 8,
  parameter int unsigned YELLOW_CYCLES = 2,
  parameter int unsigned ALLRED_CYCLES = 1,
  parameter int unsigned WALK_CYCLES   = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       ped_req,
  input  logic       flash_mode,
  output logic [2:0] light_ns,
  output logic [2:0] light_ew,
  output logic       walk,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_NS_GREEN  = 3'd0,
    S_NS_YELLOW = 3'd1,
    S_ALLRED_A  = 3'd2,
    S_EW_GREEN  = 3'd3,
    S_EW_YELLOW = 3'd4,
    S_ALLRED_B  = 3'd5,
    S_WALK      = 3'd6,
    S_FLASH     = 3'd7
  } state_e;

  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;
  localparam logic [2:0] LT_OFF = 3'b000;

  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_CYCLES - 1);
  localparam logic [CNT_W-1:0] WALK_LD   = CNT_W'(WALK_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ped_pending_q, ped_pending_d;
  logic             next_ew_q, next_ew_d;
  logic             blink_q, blink_d;
  logic [2:0]       ns_q, ns_d;
  logic [2:0]       ew_q, ew_d;
  logic             walk_q, walk_d;

  // Duration-1 loaded into the phase counter on entry to a state.
  function automatic logic [CNT_W-1:0] load_val(input state_e s);
    logic [CNT_W-1:0] v;
    case (s)
      S_NS_GREEN, S_EW_GREEN:             v = GREEN_LD;
      S_NS_YELLOW, S_EW_YELLOW, S_FLASH:  v = YELLOW_LD;
      S_ALLRED_A, S_ALLRED_B:             v = ALLRED_LD;
      S_WALK:                             v = WALK_LD;
      default:                            v = GREEN_LD;
    endcase
    return v;
  endfunction

  // Next-state, timer, pedestrian latch and blink logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    next_ew_d     = next_ew_q;
    blink_d       = blink_q;
    // Requests latch every clock, independent of enable; ignored while walking.
    ped_pending_d = ped_pending_q | (ped_req & (state_q != S_WALK));

    if (flash_mode) begin
      if (state_q != S_FLASH) begin
        state_d = S_FLASH;
        cnt_d   = YELLOW_LD;
        blink_d = 1'b1;
      end else if (enable) begin
        if (cnt_q == '0) begin
          blink_d = ~blink_q;
          cnt_d   = YELLOW_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    end else if (state_q == S_FLASH) begin
      // Leaving flash always goes through a full clearance phase.
      state_d = S_ALLRED_B;
      cnt_d   = ALLRED_LD;
    end else if (enable) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        case (state_q)
          S_NS_GREEN:  state_d = S_NS_YELLOW;
          S_NS_YELLOW: state_d = S_ALLRED_A;
          S_ALLRED_A: begin
            if (ped_pending_q | ped_req) begin
              state_d   = S_WALK;
              next_ew_d = 1'b1;
            end else begin
              state_d = S_EW_GREEN;
            end
          end
          S_EW_GREEN:  state_d = S_EW_YELLOW;
          S_EW_YELLOW: state_d = S_ALLRED_B;
          S_ALLRED_B: begin
            if (ped_pending_q | ped_req) begin
              state_d   = S_WALK;
              next_ew_d = 1'b0;
            end else begin
              state_d = S_NS_GREEN;
            end
          end
          S_WALK:      state_d = next_ew_q ? S_EW_GREEN : S_NS_GREEN;
          default:     state_d = S_NS_GREEN;
        endcase
        cnt_d = load_val(state_d);
      end
    end

    if ((state_d == S_FLASH) || ((state_d == S_WALK) && (state_q != S_WALK))) begin
      ped_pending_d = 1'b0;
    end
  end

  // Output decode from the next state so the registered outputs track state_q.
  always_comb begin
    ns_d   = LT_RED;
    ew_d   = LT_RED;
    walk_d = 1'b0;
    case (state_d)
      S_NS_GREEN:  ns_d = LT_GRN;
      S_NS_YELLOW: ns_d = LT_YEL;
      S_EW_GREEN:  ew_d = LT_GRN;
      S_EW_YELLOW: ew_d = LT_YEL;
      S_WALK:      walk_d = 1'b1;
      S_FLASH: begin
        ns_d = blink_d ? LT_YEL : LT_OFF;
        ew_d = blink_d ? LT_YEL : LT_OFF;
      end
      default: begin
        ns_d = LT_RED;
        ew_d = LT_RED;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_NS_GREEN;
      cnt_q         <= GREEN_LD;
      ped_pending_q <= 1'b0;
      next_ew_q     <= 1'b0;
      blink_q       <= 1'b1;
      ns_q          <= LT_GRN;
      ew_q          <= LT_RED;
      walk_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ped_pending_q <= ped_pending_d;
      next_ew_q     <= next_ew_d;
      blink_q       <= blink_d;
      ns_q          <= ns_d;
      ew_q          <= ew_d;
      walk_q        <= walk_d;
    end
  end

  assign light_ns = ns_q;
  assign light_ew = ew_q;
  assign walk     = walk_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed self-checking bench for traffic_light_ctrl: default-parameter
// instance for sequence/pedestrian/freeze/flash/reset, and an overridden
// instance for the short-period configuration.
module tb_traffic_light_ctrl;

  logic       clock;
  logic       reset;
  logic       enable;
  logic       ped_req;
  logic       flash_mode;
  logic [2:0] light_ns, light_ew, state_o;
  logic       walk;
  logic [2:0] light_ns2, light_ew2, state_o2;
  logic       walk2;

  int n_checks = 0;
  int n_fails  = 0;

  traffic_light_ctrl dut (
    .clock(clock), .reset(reset), .enable(enable), .ped_req(ped_req),
    .flash_mode(flash_mode), .light_ns(light_ns), .light_ew(light_ew),
    .walk(walk), .state_o(state_o)
  );

  traffic_light_ctrl #(
    .GREEN_CYCLES(3), .YELLOW_CYCLES(1), .ALLRED_CYCLES(2), .WALK_CYCLES(1), .CNT_W(4)
  ) dut2 (
    .clock(clock), .reset(reset), .enable(enable), .ped_req(ped_req),
    .flash_mode(flash_mode), .light_ns(light_ns2), .light_ew(light_ew2),
    .walk(walk2), .state_o(state_o2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expected lights per state code (flash handled separately).
  function automatic logic [2:0] exp_ns(input logic [2:0] st);
    case (st)
      3'd0: return 3'b001;
      3'd1: return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] exp_ew(input logic [2:0] st);
    case (st)
      3'd3: return 3'b001;
      3'd4: return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic unsafe(input logic [2:0] ns, input logic [2:0] ew,
                                  input logic w, input logic [2:0] st);
    return ((st != 3'd7) && (ns != 3'b100) && (ew != 3'b100)) ||
           (w && ((ns != 3'b100) || (ew != 3'b100)));
  endfunction

  // Observe n cycles of state st on the default instance.
  task automatic phase(input logic [2:0] st, input int n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("state_s%0d_c%0d", st, i), 32'(state_o), 32'(st));
      check($sformatf("ns_s%0d", st), 32'(light_ns), 32'(exp_ns(st)));
      check($sformatf("ew_s%0d", st), 32'(light_ew), 32'(exp_ew(st)));
      check($sformatf("walk_s%0d", st), 32'(walk), 32'(st == 3'd6));
      tick();
    end
  endtask

  task automatic phase2(input logic [2:0] st, input int n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("dut2_state_s%0d_c%0d", st, i), 32'(state_o2), 32'(st));
      tick();
    end
  endtask

  task automatic flash_obs(input logic [2:0] pat, input int n);
    for (int i = 0; i < n; i++) begin
      check("flash_state", 32'(state_o), 32'd7);
      check("flash_ns", 32'(light_ns), 32'(pat));
      check("flash_ew", 32'(light_ew), 32'(pat));
      check("flash_walk", 32'(walk), 32'd0);
      tick();
    end
  endtask

  // Safety invariant on both instances every cycle.
  always @(negedge clock) begin
    if (!reset) begin
      check("safety_dut", 32'(unsafe(light_ns, light_ew, walk, state_o)), 32'd0);
      check("safety_dut2", 32'(unsafe(light_ns2, light_ew2, walk2, state_o2)), 32'd0);
    end
  end

  initial begin
    reset      = 1'b1;
    enable     = 1'b1;
    ped_req    = 1'b0;
    flash_mode = 1'b0;
    tick();
    tick();

    // 1: reset state and default 22-cycle period
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_ns", 32'(light_ns), 32'h1);
    check("rst_ew", 32'(light_ew), 32'h4);
    check("rst_walk", 32'(walk), 32'd0);
    reset = 1'b0;
    phase(0, 8); phase(1, 2); phase(2, 1); phase(3, 8); phase(4, 2); phase(5, 1);

    // 2: one-cycle pedestrian pulse in NS_GREEN cycle 3
    phase(0, 2);
    ped_req = 1'b1;
    phase(0, 1);
    ped_req = 1'b0;
    phase(0, 5); phase(1, 2); phase(2, 1);
    phase(6, 4);
    phase(3, 8); phase(4, 2); phase(5, 1);
    phase(0, 8); phase(1, 2); phase(2, 1);

    // 3: freeze for 5 cycles mid EW_GREEN with a request during the freeze
    phase(3, 3);
    enable  = 1'b0;
    ped_req = 1'b1;
    phase(3, 1);
    ped_req = 1'b0;
    phase(3, 4);
    enable = 1'b1;
    phase(3, 5);
    phase(4, 2); phase(5, 1);
    phase(6, 4);
    phase(0, 8); phase(1, 2); phase(2, 1);

    // 4: flash mode from EW_GREEN, request during flash must not survive
    phase(3, 2);
    flash_mode = 1'b1;
    phase(3, 1);
    flash_obs(3'b010, 2);
    ped_req = 1'b1;
    flash_obs(3'b000, 1);
    ped_req = 1'b0;
    flash_obs(3'b000, 1);
    flash_obs(3'b010, 2);
    flash_mode = 1'b0;
    flash_obs(3'b000, 1);
    phase(5, 1);

    // 5: async reset mid NS_YELLOW discards pending request
    phase(0, 3);
    ped_req = 1'b1;
    phase(0, 1);
    ped_req = 1'b0;
    phase(0, 4);
    phase(1, 1);
    #1;
    reset = 1'b1;
    #1;
    check("async_rst_state", 32'(state_o), 32'd0);
    check("async_rst_ns", 32'(light_ns), 32'h1);
    check("async_rst_ew", 32'(light_ew), 32'h4);
    check("async_rst_walk", 32'(walk), 32'd0);
    reset = 1'b0;
    phase(0, 8); phase(1, 2); phase(2, 1); phase(3, 1);

    // 6: overridden instance, 12-cycle period over two rounds
    reset = 1'b1;
    #1;
    reset = 1'b0;
    for (int r = 0; r < 2; r++) begin
      phase2(0, 3); phase2(1, 1); phase2(2, 2); phase2(3, 3); phase2(4, 1); phase2(5, 2);
    end
    check("dut2_wrap", 32'(state_o2), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
